demux2_fifos: RTL and testbench
===============================

# demux2_fifos

Two-way demultiplexer with per-channel buffering: routes one valid/ready input stream to one of two output channels selected per beat by `sel_i`, each channel backed by its own small FIFO. It is the fan-out counterpart to the mux2-and-gate merge cell. It sits where a shared bus must be split into two independently back-pressured consumers. It is built from the 74LVC cell set: counters, registers and gating only.

## Interface
- `WIDTH`, default 8, data bits per beat (≥1)
- `DEPTH`, default 2, entries per channel FIFO (power of two, ≥2)

- `clk_i` input 1, single clock, rising edge
- `rst_ni` input 1, asynchronous active-low reset
- `data_i` input WIDTH, input beat
- `sel_i` input 1, target channel of the current beat (0 or 1)
- `valid_i` input 1, input beat valid
- `ready_o` output 1, selected channel can accept
- `flush_i` input 1, synchronous clear of both channels
- `data_o` output [1:0][WIDTH], head entry of each channel
- `valid_o` output [1:0], channel non-empty
- `ready_i` input [1:0], consumer accepts head
- `count_o` output [1:0][$clog2(DEPTH)+1], fill level per channel

## Operation
- Push: `valid_i && ready_o` writes `data_i` into the FIFO of channel `sel_i` at the rising edge.
- `ready_o = !full[sel_i] && !flush_i`. `ready_o` never depends on `ready_i`, so there is no combinational path from the consumer to the producer.
- Pop: for each channel c, `valid_o[c] && ready_i[c]` advances the channel's read pointer. Both channels pop independently in the same cycle.
- `valid_o[c] = (count[c] != 0)`. `data_o[c]` is the entry at the read pointer.
- Push and pop on the same channel in the same cycle: both take effect and the count is unchanged. A full channel refuses the push even if it pops that cycle.
- A push to one channel and a pop from the other are fully independent.
- `valid_i` low: `sel_i` and `data_i` are don't-care. `sel_i` may change every cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is one bit wider and ranges 0..DEPTH.
- Flush: when `flush_i` is high, both channels' pointers and counts clear at the edge. Flush has priority over push and pop, and pops are ignored that cycle.
- Reset: asynchronous and immediate. All pointers, counts and storage clear to 0. Reset asserted mid-transfer discards all contents.

## Timing
- Reset values:
  - `ready_o` = 1 (both channels empty)
  - `valid_o` = 2'b00
  - `count_o` = 0
  - `data_o` = 0
- Latency: a beat pushed at edge N is visible on `valid_o`/`data_o` after edge N (next cycle). There is no fall-through path.
- Throughput: one push per cycle, plus one pop per channel per cycle.
- `count_o` and `valid_o` update at the same edge as the push or pop that changes them.

## Configuration
- `DEMUX2_FIFOS_GATE_EN` defined: `data_o[c]` is ANDed with `valid_o[c]` and reads all-zero whenever the channel is empty.
- Not defined: `data_o[c]` always shows the storage word at the read pointer, including a stale value when empty. Only `valid_o` qualifies it.
- Handshake, counts and latency are identical in both builds.

## Structure
- Package `demux2_fifos_pkg`:
  - channel count constant `NumChan = 2`
  - function computing pointer width from DEPTH
  - typedef for channel index
- Sub-module `demux2_chan_fifo`, instantiated twice:
  - one-write, one-read FIFO with push, pop, flush, full, empty and count
  - optional output gating under the macro
- Top level holds the select decode, the ready mux and the handshake qualification.

## Test plan
- Reset mid-traffic (channel 0 holding 2 entries), then release:
  - response: `count_o` = {0,0}, `valid_o` = 00, `data_o` = 0, `ready_o` = 1
- Push 0xA5 with sel=0, then 0x3C with sel=1, consumers ready:
  - response: `valid_o[0]` rises the next cycle with 0xA5, then `valid_o[1]` with 0x3C
- DEPTH=2, `ready_i` = 00, push 3 beats to channel 1:
  - response: first two are accepted and `count_o[1]` = 2
  - `ready_o` drops for sel=1 but stays 1 for sel=0
- Channel 1 full, push and pop on channel 1 in the same cycle:
  - response: push is refused, count goes 2→1, then the next push is accepted
- Alternate pushes to a full channel 1 and an empty channel 0:
  - response: only channel 0 beats are accepted and arrive in order
- Assert `flush_i` together with a push and both pops:
  - response: counts go to 0 and no beat is stored
  - with the macro, `data_o` = 0; without it, `data_o` shows a stale word while `valid_o` = 00

Source files
------------

// File: rtl/demux2_fifos_pkg.sv
// demux2_fifos_pkg: shared constants, channel index type and pointer-width helper
package demux2_fifos_pkg;
  localparam int NumChan = 2;
  typedef logic [0:0] chan_t;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/demux2_chan_fifo.sv
// demux2_chan_fifo: one-write/one-read channel FIFO with flush and fill count
// DEMUX2_FIFOS_GATE_EN: gate data_o to zero while the FIFO is empty
module demux2_chan_fifo
  import demux2_fifos_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ptr_w(DEPTH):0]  count_o
);
  localparam int PW = ptr_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  assign full_o  = r_count == (PW+1)'(DEPTH);
  assign empty_o = r_count == '0;
  assign count_o = r_count;
  // a full FIFO refuses a push even when it pops in the same cycle
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && !empty_o && !flush_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end
`ifdef DEMUX2_FIFOS_GATE_EN
  assign data_o = r_mem[r_rptr] & {WIDTH{!empty_o}};
`else
  assign data_o = r_mem[r_rptr];
`endif
endmodule

// File: rtl/demux2_fifos.sv
// demux2_fifos: valid/ready stream demux into two independently buffered channels
// DEMUX2_FIFOS_GATE_EN: zero data_o of empty channels (handled in demux2_chan_fifo)
module demux2_fifos
  import demux2_fifos_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [WIDTH-1:0]                     data_i,
  input  logic                                 sel_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic                                 flush_i,
  output logic [NumChan-1:0][WIDTH-1:0]        data_o,
  output logic [NumChan-1:0]                   valid_o,
  input  logic [NumChan-1:0]                   ready_i,
  output logic [NumChan-1:0][ptr_w(DEPTH):0]   count_o
);
  chan_t              w_sel;
  logic [NumChan-1:0] w_sel_oh;
  logic [NumChan-1:0] w_full;
  logic [NumChan-1:0] w_empty;
  logic [NumChan-1:0] w_push;
  logic [NumChan-1:0] w_pop;
  assign w_sel    = chan_t'(sel_i);
  assign w_sel_oh = w_sel ? 2'b10 : 2'b01;
  // ready_o looks only at the fill state, never at ready_i
  assign ready_o  = !w_full[w_sel] && !flush_i;
  assign valid_o  = ~w_empty;
  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    assign w_push[c] = valid_i && ready_o && w_sel_oh[c];
    assign w_pop[c]  = !w_empty[c] && ready_i[c] && !flush_i;
    demux2_chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .push_i (w_push[c]),
      .pop_i  (w_pop[c]),
      .data_i (data_i),
      .data_o (data_o[c]),
      .full_o (w_full[c]),
      .empty_o(w_empty[c]),
      .count_o(count_o[c])
    );
  end
endmodule

// File: tb/tb_demux2_fifos.sv
// tb_demux2_fifos: directed and random scoreboard bench for demux2_fifos
module tb_demux2_fifos;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;
  logic                      clk = 1'b0;
  logic                      rst_ni = 1'b0;
  logic [WIDTH-1:0]          data_i = '0;
  logic                      sel_i = 1'b0;
  logic                      valid_i = 1'b0;
  logic                      ready_o;
  logic                      flush_i = 1'b0;
  logic [1:0][WIDTH-1:0]     data_o;
  logic [1:0]                valid_o;
  logic [1:0]                ready_i = 2'b00;
  logic [1:0][CW-1:0]        count_o;
  int n_chk = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  always #5 clk = ~clk;

  demux2_fifos #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .data_i (data_i),
    .sel_i  (sel_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .flush_i(flush_i),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .count_o(count_o)
  );

  function automatic int qs(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [WIDTH-1:0] qpop(input int c);
    if (c == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // drive one beat at posedge+2, update the model just after the edge it lands on
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic f, input logic [1:0] ri);
    logic acc;
    valid_i = v; sel_i = s; data_i = d; flush_i = f; ready_i = ri;
    acc = v && !f && (qs(int'(s)) < DEPTH);
    @(posedge clk);
    #1;
    if (f) begin
      q0.delete();
      q1.delete();
    end else if (acc) begin
      if (s) q1.push_back(d);
      else q0.push_back(d);
    end
    #1;
  endtask

  // monitor: checks handshake/levels every cycle and pops the scoreboard on each consumed beat
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("ready_o", 32'(ready_o), 32'(!flush_i && qs(int'(sel_i)) < DEPTH));
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("valid_o[%0d]", c), 32'(valid_o[c]), 32'(qs(c) != 0));
        chk($sformatf("count_o[%0d]", c), 32'(count_o[c]), 32'(qs(c)));
        if (valid_o[c] && ready_i[c] && !flush_i && qs(c) != 0)
          chk($sformatf("data_o[%0d]", c), 32'(data_o[c]), 32'(qpop(c)));
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, " ready_o"}, 32'(ready_o), 32'd1);
    chk({tag, " valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, " count_o"}, 32'(count_o), 32'd0);
    chk({tag, " data_o"}, 32'(data_o), 32'd0);
  endtask

  initial begin
    #1;
    chk_reset_state("por");
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    // reset mid-traffic with channel 0 holding two entries
    step(1'b1, 1'b0, 8'h55, 1'b0, 2'b00);
    step(1'b1, 1'b0, 8'h66, 1'b0, 2'b00);
    chk("pre-reset count0", 32'(count_o[0]), 32'd2);
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_reset_state("mid");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    // flush with push and both pops: nothing stored, stale or gated data
    step(1'b1, 1'b0, 8'h11, 1'b0, 2'b00);
    step(1'b1, 1'b0, 8'h22, 1'b1, 2'b11);
    chk("flush count", 32'(count_o), 32'd0);
    chk("flush valid", 32'(valid_o), 32'd0);
`ifdef DEMUX2_FIFOS_GATE_EN
    chk("flush data0", 32'(data_o[0]), 32'h00);
`else
    chk("flush data0", 32'(data_o[0]), 32'h11);
`endif
    chk("flush data1", 32'(data_o[1]), 32'h00);
    // one-cycle latency into each channel
    step(1'b1, 1'b0, 8'hA5, 1'b0, 2'b11);
    chk("lat valid0", 32'(valid_o[0]), 32'd1);
    chk("lat data0", 32'(data_o[0]), 32'hA5);
    step(1'b1, 1'b1, 8'h3C, 1'b0, 2'b11);
    chk("lat valid1", 32'(valid_o[1]), 32'd1);
    chk("lat data1", 32'(data_o[1]), 32'h3C);
    chk("lat pop0", 32'(valid_o[0]), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b11);
    // fill channel 1 with three attempts
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 2'b00);
    chk("full count1", 32'(count_o[1]), 32'd2);
    valid_i = 1'b0;
    sel_i = 1'b1;
    #1 chk("ready sel1 full", 32'(ready_o), 32'd0);
    sel_i = 1'b0;
    #1 chk("ready sel0 empty", 32'(ready_o), 32'd1);
    // full channel: push refused while popping, next push accepted
    step(1'b1, 1'b1, 8'h77, 1'b0, 2'b10);
    chk("push+pop count1", 32'(count_o[1]), 32'd1);
    step(1'b1, 1'b1, 8'h88, 1'b0, 2'b00);
    chk("refill count1", 32'(count_o[1]), 32'd2);
    // alternate between full channel 1 and empty channel 0
    for (int i = 0; i < 4; i++) step(1'b1, (i % 2) == 0, 8'h90 + 8'(i), 1'b0, 2'b00);
    chk("alt count0", 32'(count_o[0]), 32'd2);
    chk("alt count1", 32'(count_o[1]), 32'd2);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b11);
    // random traffic
    repeat (800)
      step(($urandom % 4) != 0, 1'($urandom), 8'($urandom), ($urandom % 25) == 0, 2'($urandom));
    repeat (6) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b11);
    chk("drain model", 32'(q0.size() + q1.size()), 32'd0);
    chk("drain count", 32'(count_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
